// File: rtl/seq_shift_pkg.sv
// seq_shift_pkg: operation and state encodings shared by the shift register and its step shifter
package seq_shift_pkg;
   typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL} op_e;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
endpackage

// File: rtl/seq_shift_step.sv
// seq_shift_step: combinational single-bit shift/rotate of d by the given op
module seq_shift_step
   import seq_shift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] q
);
   always_comb
      q = op == OP_SLL ? {d[WIDTH-2:0], 1'b0} :
          op == OP_SRL ? {1'b0, d[WIDTH-1:1]} :
          op == OP_SRA ? {d[WIDTH-1], d[WIDTH-1:1]} :
                         {d[WIDTH-2:0], d[WIDTH-1]};
endmodule

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: parallel-load register with a one-bit-per-cycle shift/rotate engine;
// defining SEQ_SHIFT_BARREL_EN replaces the engine with a single-cycle barrel shifter
module seq_shift_reg
   import seq_shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [WIDTH-1:0]   in1,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   out1,
   output logic               busy,
   output logic               done
);
   state_e             state, state_nxt;
   op_e                op_q, op_nxt;
   logic [SHAMT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0]   out_nxt, step_val;
   seq_shift_step #(.WIDTH(WIDTH)) u_step (.d(out1), .op(op_q), .q(step_val));
`ifdef SEQ_SHIFT_BARREL_EN
   localparam int NSTG = 2 ** SHAMT_W;
   logic [WIDTH-1:0] stg [NSTG];
   assign stg[0] = out1;
   // stage g holds out1 stepped g times, so shamt >= WIDTH matches the sequential result
   for (genvar g = 1; g < NSTG; g++) begin : g_stg
      seq_shift_step #(.WIDTH(WIDTH)) u_stg (.d(stg[g-1]), .op(op), .q(stg[g]));
   end
`endif
   assign busy = state == ST_SHIFT;
   assign done = state == ST_DONE;
   always_comb begin
      state_nxt = state;
      op_nxt    = op_q;
      cnt_nxt   = cnt;
      out_nxt   = out1;
      if (state != ST_SHIFT) begin
         if (load) begin
            out_nxt   = in1;
            state_nxt = ST_IDLE;
         end else if (start) begin
            op_nxt    = op_e'(op);
`ifdef SEQ_SHIFT_BARREL_EN
            out_nxt   = stg[shamt];
            state_nxt = ST_DONE;
`else
            cnt_nxt   = shamt;
            state_nxt = shamt == '0 ? ST_DONE : ST_SHIFT;
`endif
         end else begin
            state_nxt = ST_IDLE;
         end
      end else begin
         out_nxt   = step_val;
         cnt_nxt   = cnt - 1'b1;
         state_nxt = cnt == SHAMT_W'(1) ? ST_DONE : ST_SHIFT;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= ST_IDLE;
         op_q  <= OP_SLL;
         cnt   <= '0;
         out1  <= '0;
      end else begin
         state <= state_nxt;
         op_q  <= op_nxt;
         cnt   <= cnt_nxt;
         out1  <= out_nxt;
      end
endmodule

// File: tb/tb_seq_shift_reg.sv
// tb_seq_shift_reg: randomized scoreboard bench for seq_shift_reg against an arithmetic reference model
module tb_seq_shift_reg;
   localparam int W  = 32;
   localparam int SW = 6;
`ifdef SEQ_SHIFT_BARREL_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load = 1'b0;
   logic [W-1:0]  in1 = '0;
   logic          start = 1'b0;
   logic [1:0]    op = '0;
   logic [SW-1:0] shamt = '0;
   logic [W-1:0]  out1;
   logic          busy, done;

   seq_shift_reg #(.WIDTH(W), .SHAMT_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .in1(in1), .start(start),
      .op(op), .shamt(shamt), .out1(out1), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {logic [W-1:0] val; int busy_cycles;} exp_t;
   exp_t         sb[$];
   int           checks = 0;
   int           passes = 0;
   int           busy_cnt = 0;
   logic [W-1:0] model = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input logic [1:0] o, input int k);
      int r;
      r = k % W;
      case (o)
         2'd0: return k >= W ? '0 : v << k;
         2'd1: return k >= W ? '0 : v >> k;
         2'd2: return k >= W ? {W{v[W-1]}} : W'($signed(v) >>> k);
         default: return r == 0 ? v : (v << r) | (v >> (W - r));
      endcase
   endfunction

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst_n) busy_cnt = 0;
      else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               check("done_val", out1, e.val);
               check("busy_len", W'(busy_cnt), W'(e.busy_cycles));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic do_load(input logic [W-1:0] v);
      load = 1'b1;
      in1  = v;
      @(posedge clk);
      #1 load = 1'b0;
      model = v;
      check("load", out1, v);
   endtask

   task automatic wait_done(input int lat);
      int n;
      n = 0;
      while (!done && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      if (!done) check("timeout", 32'd1, 32'd0);
      else check("done_latency", W'(n), W'(lat));
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [1:0] o, input int k);
      exp_t e;
      e.val         = ref_shift(model, o, k);
      e.busy_cycles = BARREL ? 0 : k;
      sb.push_back(e);
      start = 1'b1;
      op    = o;
      shamt = SW'(k);
      @(posedge clk);
      #1 start = 1'b0;
      model = e.val;
      wait_done(BARREL ? 0 : k);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_out1", out1, '0);
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      @(posedge clk);
      #1 do_load(32'h8000_0001);
      run_op(2'd2, 4);
      check("sra4", out1, 32'hF800_0000);
      do_load(32'h8000_0001);
      run_op(2'd3, 33);
      check("rol33", out1, 32'h0000_0003);
      do_load(32'h8000_0001);
      run_op(2'd0, 33);
      check("sll33", out1, 32'h0000_0000);
      load  = 1'b1;
      in1   = 32'h1234_5678;
      start = 1'b1;
      op    = 2'd0;
      shamt = SW'(3);
      @(posedge clk);
      #1 load = 1'b0;
      start = 1'b0;
      model = 32'h1234_5678;
      check("load_wins", out1, 32'h1234_5678);
      check("load_wins_busy", W'(busy), '0);
      repeat (3) @(posedge clk);
      #1 check("load_wins_hold", out1, 32'h1234_5678);
`ifndef SEQ_SHIFT_BARREL_EN
      begin
         exp_t e;
         e.val = ref_shift(model, 2'd1, 5);
         e.busy_cycles = 5;
         sb.push_back(e);
         start = 1'b1;
         op    = 2'd1;
         shamt = SW'(5);
         @(posedge clk);
         #1 start = 1'b0;
         load  = 1'b1;
         in1   = 32'hFFFF_FFFF;
         start = 1'b1;
         op    = 2'd3;
         shamt = SW'(1);
         @(posedge clk);
         #1 load = 1'b0;
         start = 1'b0;
         model = e.val;
         wait_done(4);
         check("busy_ignored", out1, 32'h0091_A2B3);
      end
`endif
      run_op(2'd2, 0);
      check("shamt0", out1, model);
`ifndef SEQ_SHIFT_BARREL_EN
      do_load(32'hA5A5_0F0F);
      start = 1'b1;
      op    = 2'd0;
      shamt = SW'(8);
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 check("abort_busy_before", W'(busy), 32'd1);
      rst_n = 1'b0;
      #1 check("abort_out1", out1, '0);
      check("abort_busy", W'(busy), '0);
      check("abort_done", W'(done), '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model = '0;
      repeat (12) @(posedge clk);
      #1 check("abort_hold", out1, '0);
`endif
      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 2) == 0) do_load($urandom);
         run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 40)));
      end
      check("sb_drained", W'(sb.size()), '0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
